// File: rtl/sad_engine.sv
// rtl/sad_engine.sv - sum-of-absolute-differences engine with best-candidate tracking
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   request one SAD computation (taken only in IDLE with both buffers full)
//   cur_full  in   current-block buffer full, cur_in valid
//   ref_full  in   candidate buffer full, ref_in valid
//   cur_in    in   current block, pixel i at [WIDTH*i +: WIDTH]
//   ref_in    in   candidate block, same packing
//   clr_best  in   synchronous clear of best_sad/best_idx/cand_idx
//   busy      out  computation in progress (RUN)
//   done      out  one-cycle pulse, sad valid (FIN)
//   sad       out  last completed SAD
//   best_sad  out  minimum SAD since last clear
//   best_idx  out  candidate index of best_sad
//   cand_idx  out  index the next completed candidate receives
module sad_engine #(
  parameter int WIDTH = 8,
  parameter int N     = 80,
  parameter int LANES = 4,
  parameter int SUM_W = 15,
  parameter int IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cur_full,
  input  logic                 ref_full,
  input  logic [N*WIDTH-1:0]   cur_in,
  input  logic [N*WIDTH-1:0]   ref_in,
  input  logic                 clr_best,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_W-1:0]     sad,
  output logic [SUM_W-1:0]     best_sad,
  output logic [IDX_W-1:0]     best_idx,
  output logic [IDX_W-1:0]     cand_idx
);

  localparam int BEATS = N / LANES;
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [K_W-1:0]     k;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   acc_nxt;
  logic [SUM_W-1:0]   beat_sum;
  logic               accept;
  logic               last_beat;
  logic [WIDTH:0]     lane_abs [LANES];

  assign accept    = (state == IDLE) && start && cur_full && ref_full;
  assign last_beat = (state == RUN) && (k == K_W'(BEATS - 1));

  // One absolute difference per lane for beat k. The subtraction is done in
  // WIDTH+1 bits so the sign bit tells which operand was larger; negating the
  // borrowed result gives the magnitude without wrap.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   d;

    assign a           = cur_in[WIDTH*(LANES*int'(k) + l) +: WIDTH];
    assign b           = ref_in[WIDTH*(LANES*int'(k) + l) +: WIDTH];
    assign d           = {1'b0, a} - {1'b0, b};
    assign lane_abs[l] = d[WIDTH] ? (~d + 1'b1) : d;
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + SUM_W'(lane_abs[l]);
    end
  end

  assign acc_nxt = acc + beat_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      k        <= '0;
      sad      <= '0;
      best_sad <= '1;
      best_idx <= '0;
      cand_idx <= '0;
    end else begin
      if (accept) begin
        acc <= '0;
        k   <= '0;
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        k   <= k + K_W'(1);
      end
      // Capture the total on the last beat so sad is already valid while done is high.
      if (last_beat) begin
        sad <= acc_nxt;
      end
      // Clear beats the FIN update; sad/done are unaffected by it.
      if (clr_best) begin
        best_sad <= '1;
        best_idx <= '0;
        cand_idx <= '0;
      end else if (state == FIN) begin
        if (sad < best_sad) begin
          best_sad <= sad;
          best_idx <= cand_idx;
        end
        cand_idx <= cand_idx + IDX_W'(1);
      end
    end
  end

  // Decoded from the state register only, so no input-to-output path exists.
  assign busy = (state == RUN);
  assign done = (state == FIN);

endmodule
